jar_sram_driver: RTL and testbench
==================================

# jar_sram_driver

Host-side sequencer sitting directly upstream of the nibble-serial 8-byte SRAM tile. It accepts whole-byte read/write requests over a valid/ready handshake and generates the SRAM's 8-bit pin word: clock bit, strobes and 4-bit address/data nibble. Each SRAM clock is produced as a two-cycle low/high pair. Read data is sampled back from the SRAM output pins and returned as a one-cycle response pulse.

## Interface
Parameters:
- `AW`, 4, nibble width of the shared address/data field.
- `DW`, 8, data word width; must equal 2*`AW`.
- `ADDR_W`, 3, SRAM address bits; `ADDR_W` < `AW`.

Ports:
- `clk`  in  1  system clock. One clock; the SRAM clock is derived from it.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_write`  in  1  1 = write, 0 = read.
- `req_addr`  in  `ADDR_W`  byte address.
- `req_wdata`  in  `DW`  write data.
- `rsp_valid`  out  1  one-cycle pulse carrying read data.
- `rsp_rdata`  out  `DW`  read data; holds until the next read completes.
- `wr_err`  out  1  one-cycle write-verify mismatch pulse; tied to 0 without the macro.
- `sram_io_in`  out  `DW`  registered SRAM pin word:
  - [7:4] nibble
  - [3] commit
  - [2] oe
  - [1] we
  - [0] SRAM clock
- `sram_io_out`  in  `DW`  SRAM output pins; valid while oe is high.

## Operation
- Request fields are captured at acceptance. Later changes on the request inputs are ignored until `req_ready` returns.
- Every SRAM step takes two cycles:
  - ph0: nibble and strobes driven, bit0 = 0.
  - ph1: identical, except bit0 = 1 (the SRAM rising edge).
- FSM states: IDLE, W_LO, W_HI, W_CMT, R_ADDR, R_CAP. Each non-IDLE state except R_CAP has ph0 and ph1.
- Write path: IDLE → W_LO → W_HI → W_CMT → IDLE.
  - W_LO: nibble = wdata[3:0], we = 1.
  - W_HI: nibble = wdata[7:4], we = 1.
  - W_CMT: nibble = {0, addr}, commit = 1.
- Read path: IDLE → R_ADDR → R_CAP → IDLE.
  - R_ADDR: nibble = {0, addr}, oe = 1.
  - R_CAP: single ph0 cycle, same word as R_ADDR ph0. `sram_io_out` is registered into `rsp_rdata` at the end of this cycle.
- Only one strobe is ever high at a time. The nibble MSB is 0 during address phases.
- IDLE drives `sram_io_in` = 0x00.
- Reset values: `sram_io_in` = 0x00, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0x00, `wr_err` = 0, state IDLE.
- Reset mid-operation:
  - Next cycle `sram_io_in` = 0x00 and no response is issued.
  - The SRAM holding register may be left partly shifted. This is harmless, because every write shifts in two fresh nibbles.

## Timing
- Request accepted at cycle T.
- Write:
  - `sram_io_in` is busy during T+1..T+6.
  - Back in IDLE at T+7, with `req_ready` = 1 at T+7.
- Read:
  - R_ADDR at T+1..T+2; R_CAP at T+3.
  - `rsp_valid` = 1 at T+4, with `rsp_rdata` valid from T+4.
  - `req_ready` = 1 at T+4.
- Back-to-back: a request held valid in the ready cycle is accepted there, with no gap cycle. Pin activity never overlaps.

## Configuration
- Macro `JAR_SRAM_DRV_VERIFY_EN`.
- Defined: after W_CMT, the write path continues through R_ADDR and R_CAP to the same address, without issuing a response.
  - The read-back is compared against the captured wdata.
  - On mismatch, `wr_err` pulses at T+10.
  - `req_ready` returns at T+10.
- Undefined: write timing is as above and `wr_err` is constant 0.

## Structure
- Shared package `jar_sram_pkg` holds:
  - the state enum;
  - pin bit-position constants: CLK_BIT=0, WE_BIT=1, OE_BIT=2, COMMIT_BIT=3, NIB_LSB=4;
  - default `AW`, `DW` and `ADDR_W`.
- No sub-module: the FSM, phase bit and pin-word register are inline.
- The bench instantiates the existing SRAM tile as the downstream model.

## Test plan
- Reset: assert `rst` for 2 cycles → `sram_io_in` = 0x00, `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0x00.
- Write addr 5, data 0xA3 → `sram_io_in` = 0x32, 0x33, 0xA2, 0xA3, 0x58, 0x59, then 0x00. `req_ready` is low for 6 cycles.
- Read addr 5 after that write → `sram_io_in` = 0x54, 0x55, 0x54; `rsp_valid` at T+4 with `rsp_rdata` = 0xA3.
- `req_valid` held high with a write (addr 1, 0x5C) then a read (addr 1) → the second request is accepted exactly at T+7; the read returns 0x5C.
- `rst` asserted during W_HI ph1 → next cycle `sram_io_in` = 0x00, no `rsp_valid`. A following write of 0x0F to addr 2, then a read of addr 2, returns 0x0F.
- With `JAR_SRAM_DRV_VERIFY_EN`:
  - normal write → `wr_err` stays 0 and `req_ready` returns at T+10;
  - the bench model forces one mem bit stuck → `wr_err` = 1 at T+10 for exactly one cycle.

Source files
------------

// File: rtl/jar_sram_pkg.sv
// Shared types and constants for the nibble-serial SRAM driver.
package jar_sram_pkg;

  localparam int AW_DEFAULT     = 4;
  localparam int DW_DEFAULT     = 8;
  localparam int ADDR_W_DEFAULT = 3;

  localparam int CLK_BIT    = 0;
  localparam int WE_BIT     = 1;
  localparam int OE_BIT     = 2;
  localparam int COMMIT_BIT = 3;
  localparam int NIB_LSB    = 4;

  typedef enum logic [2:0] {
    IDLE,
    W_LO,
    W_HI,
    W_CMT,
    R_ADDR,
    R_CAP
  } drv_state_e;

endpackage

// File: rtl/jar_sram_driver.sv
// Byte read/write sequencer for the nibble-serial 8-byte SRAM tile.
// Optional write read-back verify: JAR_SRAM_DRV_VERIFY_EN.
//
// state  | meaning
// IDLE   | pins 0x00, request accepted here
// W_LO   | shift wdata[3:0] (ph0/ph1)
// W_HI   | shift wdata[7:4] (ph0/ph1)
// W_CMT  | commit holding register to addr (ph0/ph1)
// R_ADDR | present addr with oe (ph0/ph1)
// R_CAP  | single ph0 cycle, sram_io_out sampled at its end
module jar_sram_driver
  import jar_sram_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int DW     = DW_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              wr_err,
  output logic [DW-1:0]     sram_io_in,
  input  logic [DW-1:0]     sram_io_out
);

  drv_state_e        state, state_nxt;
  logic              phase, phase_nxt;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DW-1:0]     cap_wdata;

  logic              accept;
  logic [ADDR_W-1:0] src_addr;
  logic [DW-1:0]     src_wdata;
  logic [AW-1:0]     nib;
  logic [DW-1:0]     word_nxt;
  logic              cap_end;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign cap_end   = (state == R_CAP);

  // The pin word is registered from the next state, so the first step must
  // use the request fields directly while they are being captured.
  assign src_addr  = accept ? req_addr  : cap_addr;
  assign src_wdata = accept ? req_wdata : cap_wdata;

  always_comb begin
    state_nxt = state;
    phase_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) state_nxt = req_write ? W_LO : R_ADDR;
      end
      W_LO: begin
        phase_nxt = ~phase;
        if (phase) state_nxt = W_HI;
      end
      W_HI: begin
        phase_nxt = ~phase;
        if (phase) state_nxt = W_CMT;
      end
      W_CMT: begin
        phase_nxt = ~phase;
`ifdef JAR_SRAM_DRV_VERIFY_EN
        if (phase) state_nxt = R_ADDR;
`else
        if (phase) state_nxt = IDLE;
`endif
      end
      R_ADDR: begin
        phase_nxt = ~phase;
        if (phase) state_nxt = R_CAP;
      end
      R_CAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pin layout assumes DW == AW + 4 (nibble above the four control bits).
  always_comb begin
    nib      = '0;
    word_nxt = '0;
    case (state_nxt)
      W_LO: begin
        nib              = src_wdata[AW-1:0];
        word_nxt[WE_BIT] = 1'b1;
      end
      W_HI: begin
        nib              = src_wdata[DW-1:AW];
        word_nxt[WE_BIT] = 1'b1;
      end
      W_CMT: begin
        nib                  = AW'(src_addr);
        word_nxt[COMMIT_BIT] = 1'b1;
      end
      R_ADDR, R_CAP: begin
        nib              = AW'(src_addr);
        word_nxt[OE_BIT] = 1'b1;
      end
      default: begin
        nib = '0;
      end
    endcase
    word_nxt[NIB_LSB +: AW] = nib;
    word_nxt[CLK_BIT]       = phase_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 1'b0;
      sram_io_in <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      cap_write  <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      sram_io_in <= word_nxt;
      rsp_valid  <= cap_end && !cap_write;
      if (cap_end && !cap_write) rsp_rdata <= sram_io_out;
      if (accept) begin
        cap_write <= req_write;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
    end
  end

`ifdef JAR_SRAM_DRV_VERIFY_EN
  always_ff @(posedge clk) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= cap_end && cap_write && (sram_io_out != cap_wdata);
  end
`else
  assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_jar_sram_driver.sv
// Bench for jar_sram_driver: behavioural SRAM tile downstream, per-cycle
// reference model of the pin sequence and responses, plus literal checks.
module tb_jar_sram_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [2:0] req_addr  = 3'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready, rsp_valid, wr_err;
  logic [7:0] rsp_rdata, sram_io_in, sram_io_out;

  always #5 clk = ~clk;

  jar_sram_driver dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .wr_err     (wr_err),
    .sram_io_in (sram_io_in),
    .sram_io_out(sram_io_out)
  );

`ifdef JAR_SRAM_DRV_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int WR_BUSY = VERIFY ? 9 : 6;

  // SRAM tile: acts on rising edges of pin bit0
  logic [7:0] tile_mem [0:7];
  logic [7:0] tile_hold = 8'h00;
  logic [2:0] tile_raddr = 3'd0;
  logic [7:0] stuck_mask = 8'h00;
  wire        sram_clk = sram_io_in[0];

  always @(posedge sram_clk) begin
    if (sram_io_in[1]) tile_hold <= {sram_io_in[7:4], tile_hold[7:4]};
    if (sram_io_in[3]) tile_mem[sram_io_in[6:4]] <= tile_hold;
    if (sram_io_in[2]) tile_raddr <= sram_io_in[6:4];
  end
  assign sram_io_out = sram_io_in[2] ? (tile_mem[tile_raddr] & ~stuck_mask) : 8'h00;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model
  logic [7:0] pin_q [$];
  logic [7:0] ref_mem [0:7];
  int         rsp_cnt = 0, err_cnt = 0, wr_cnt = 0;
  logic [7:0] rsp_pend = 8'h00, exp_rdata = 8'h00;
  bit         err_pend = 1'b0;
  logic [2:0] wr_pend_addr = 3'd0;
  logic [7:0] wr_pend_data = 8'h00;

  logic [7:0] pin_log   [0:4095];
  logic [7:0] rd_log    [0:4095];
  bit         rv_log    [0:4095];
  bit         ready_log [0:4095];
  bit         err_log   [0:4095];
  int         acc_log   [$];

  logic [7:0] e_pin;
  bit         e_ready, e_rv, e_err;

  always @(negedge clk) begin
    if (checking) begin
      e_ready = (pin_q.size() == 0);
      e_pin   = e_ready ? 8'h00 : pin_q.pop_front();
      e_rv    = 1'b0;
      e_err   = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          e_rv      = 1'b1;
          exp_rdata = rsp_pend;
        end
      end
      if (err_cnt > 0) begin
        err_cnt--;
        if (err_cnt == 0) e_err = err_pend;
      end
      if (wr_cnt > 0) begin
        wr_cnt--;
        if (wr_cnt == 0) ref_mem[wr_pend_addr] = wr_pend_data;
      end
      chk("sram_io_in", sram_io_in, e_pin);
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("wr_err", wr_err, e_err);
      if (cyc < 4096) begin
        pin_log[cyc]   = sram_io_in;
        rd_log[cyc]    = rsp_rdata;
        rv_log[cyc]    = rsp_valid;
        ready_log[cyc] = req_ready;
        err_log[cyc]   = wr_err;
      end
      if (rst) begin
        pin_q.delete();
        rsp_cnt   = 0;
        err_cnt   = 0;
        wr_cnt    = 0;
        exp_rdata = 8'h00;
      end else if (req_valid && e_ready) begin
        acc_log.push_back(cyc);
        if (req_write) begin
          pin_q.push_back({req_wdata[3:0], 4'b0010});
          pin_q.push_back({req_wdata[3:0], 4'b0011});
          pin_q.push_back({req_wdata[7:4], 4'b0010});
          pin_q.push_back({req_wdata[7:4], 4'b0011});
          pin_q.push_back({1'b0, req_addr, 4'b1000});
          pin_q.push_back({1'b0, req_addr, 4'b1001});
          wr_cnt       = 6;
          wr_pend_addr = req_addr;
          wr_pend_data = req_wdata;
          if (VERIFY) begin
            pin_q.push_back({1'b0, req_addr, 4'b0100});
            pin_q.push_back({1'b0, req_addr, 4'b0101});
            pin_q.push_back({1'b0, req_addr, 4'b0100});
            err_cnt  = 10;
            err_pend = ((req_wdata & ~stuck_mask) != req_wdata);
          end
        end else begin
          pin_q.push_back({1'b0, req_addr, 4'b0100});
          pin_q.push_back({1'b0, req_addr, 4'b0101});
          pin_q.push_back({1'b0, req_addr, 4'b0100});
          rsp_cnt  = 4;
          rsp_pend = ref_mem[req_addr];
        end
      end
    end
  end

  // Returns the acceptance cycle; leaves the bench one step into the next cycle.
  task automatic do_req(input logic w, input logic [2:0] a, input logic [7:0] d,
                        input bit hold, output int t);
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 40 && t < 0; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        t = cyc - 1;
      end
    end
    if (t < 0) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no acceptance expected acceptance within 40 cycles");
      t = 0;
    end
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    int t, t2, n;
    logic [7:0] exp_w [0:5];
    for (int i = 0; i < 8; i++) begin
      tile_mem[i] = 8'h00;
      ref_mem[i]  = 8'h00;
    end
    exp_w[0] = 8'h32; exp_w[1] = 8'h33; exp_w[2] = 8'hA2;
    exp_w[3] = 8'hA3; exp_w[4] = 8'h58; exp_w[5] = 8'h59;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;
    @(negedge clk);
    chk("rst_pins", sram_io_in, 8'h00);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 8'h00);

    // Write addr 5 <- 0xA3
    do_req(1'b1, 3'd5, 8'hA3, 1'b0, t);
    settle(WR_BUSY + 3);
    for (int i = 0; i < 6; i++) chk("wr_pin_seq", pin_log[t + 1 + i], exp_w[i]);
    chk("wr_pin_idle", pin_log[t + WR_BUSY + 1], 8'h00);
    n = 0;
    for (int i = 1; i <= 12 && !ready_log[t + i]; i++) n++;
    chk("wr_busy_len", n, WR_BUSY);

    // Read addr 5
    do_req(1'b0, 3'd5, 8'h00, 1'b0, t);
    settle(6);
    chk("rd_pin0", pin_log[t + 1], 8'h54);
    chk("rd_pin1", pin_log[t + 2], 8'h55);
    chk("rd_pin2", pin_log[t + 3], 8'h54);
    chk("rd_valid_early", rv_log[t + 3], 1'b0);
    chk("rd_valid", rv_log[t + 4], 1'b1);
    chk("rd_data", rd_log[t + 4], 8'hA3);
    chk("rd_ready_back", ready_log[t + 4], 1'b1);

    // Back-to-back with req_valid held
    do_req(1'b1, 3'd1, 8'h5C, 1'b1, t);
    do_req(1'b0, 3'd1, 8'h00, 1'b0, t2);
    settle(6);
    chk("b2b_gap", t2 - t, WR_BUSY + 1);
    chk("b2b_valid", rv_log[t2 + 4], 1'b1);
    chk("b2b_data", rd_log[t2 + 4], 8'h5C);

    // Reset during W_HI ph1 of a write to addr 3
    do_req(1'b1, 3'd3, 8'h77, 1'b0, t);
    settle(3);
    rst = 1'b1;
    settle(1);
    rst = 1'b0;
    settle(12);
    chk("rst_mid_pin_before", pin_log[t + 4], 8'h73);
    chk("rst_mid_pin_after", pin_log[t + 5], 8'h00);
    chk("rst_mid_ready", ready_log[t + 5], 1'b1);
    n = 0;
    for (int i = 1; i <= 12; i++) n += rv_log[t + i];
    chk("rst_mid_no_rsp", n, 0);
    do_req(1'b1, 3'd2, 8'h0F, 1'b0, t);
    settle(WR_BUSY + 2);
    do_req(1'b0, 3'd2, 8'h00, 1'b0, t2);
    settle(6);
    chk("post_rst_data", rd_log[t2 + 4], 8'h0F);
    chk("post_rst_valid", rv_log[t2 + 4], 1'b1);

`ifdef JAR_SRAM_DRV_VERIFY_EN
    do_req(1'b1, 3'd4, 8'h96, 1'b0, t);
    settle(14);
    chk("vfy_busy_end", ready_log[t + 9], 1'b0);
    chk("vfy_ready_back", ready_log[t + 10], 1'b1);
    n = 0;
    for (int i = 1; i <= 13; i++) n += err_log[t + i];
    chk("vfy_no_err", n, 0);

    stuck_mask = 8'h01;
    do_req(1'b1, 3'd6, 8'h01, 1'b0, t);
    settle(14);
    stuck_mask = 8'h00;
    chk("vfy_err_pulse", err_log[t + 10], 1'b1);
    n = 0;
    for (int i = 1; i <= 13; i++) n += err_log[t + i];
    chk("vfy_err_once", n, 1);
`endif

    settle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
